// File: rtl/xbar_pkg.sv
// Shared widths and helpers for the crossbar ingress arbiter.
package xbar_pkg;

    localparam int DENY_CNT_W = 16;

    // Index width for a count of n items; a single item still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Round-robin picker for one destination: one-hot grant to the first request
// found at or after ptr, searching cyclically.
module xbar_rr_pick
    import xbar_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SRC_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [SRC_W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        idx   = '0;
        // Walk backwards so the candidate nearest ptr is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = SRC_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_ingress_arbiter.sv
// Ingress arbiter for an N-source x M-destination crossbar with per-destination
// round-robin; define XBAR_PERM_CHECK_EN to enable the permission table and deny logic.
module xbar_ingress_arbiter
    import xbar_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int M      = 4,
    parameter  int DW     = 32,
    localparam int DEST_W = idx_w(M),
    localparam int SRC_W  = idx_w(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             in_valid,
    input  logic [N-1:0][DEST_W-1:0] in_dest,
    input  logic [N-1:0][DW-1:0]     in_data,
    output logic [N-1:0]             in_ready,
    output logic [N-1:0]             out_req,
    output logic [N-1:0][DEST_W-1:0] out_dest,
    output logic [N-1:0][DW-1:0]     out_data,
    input  logic                     perm_we,
    input  logic [SRC_W-1:0]         perm_src,
    input  logic [M-1:0]             perm_mask,
    output logic [N-1:0]             deny,
    output logic [DENY_CNT_W-1:0]    deny_cnt
);

    logic [N-1:0][M-1:0]     perm;
    logic [N-1:0][M-1:0]     hit;
    logic [M-1:0][N-1:0]     elig;
    logic [M-1:0][N-1:0]     grant;
    logic [N-1:0]            granted;
    logic [N-1:0]            denied;
    logic [M-1:0][SRC_W-1:0] rr_q, rr_d;
    logic [N-1:0]            out_req_q, out_req_d;
    logic [N-1:0][DEST_W-1:0] out_dest_q, out_dest_d;
    logic [N-1:0][DW-1:0]    out_data_q, out_data_d;

    // A destination index >= M matches no hit bit, so it is denied like a perm miss.
    always_comb begin
        hit    = '0;
        elig   = '0;
        denied = '0;
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < M; d++) begin
                hit[i][d]  = (in_dest[i] == DEST_W'(d));
                elig[d][i] = in_valid[i] & hit[i][d] & perm[i][d];
            end
            denied[i] = in_valid[i] & ~|(hit[i] & perm[i]);
        end
    end

    for (genvar d = 0; d < M; d++) begin : g_pick
        xbar_rr_pick #(.N(N)) u_pick (
            .req   (elig[d]),
            .ptr   (rr_q[d]),
            .grant (grant[d])
        );
    end

    always_comb begin
        granted    = '0;
        rr_d       = rr_q;
        out_dest_d = out_dest_q;
        out_data_d = out_data_q;
        for (int d = 0; d < M; d++) begin
            for (int i = 0; i < N; i++) begin
                if (grant[d][i]) begin
                    granted[i] = 1'b1;
                    rr_d[d]    = (i == N - 1) ? '0 : SRC_W'(i + 1);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                out_dest_d[i] = in_dest[i];
                out_data_d[i] = in_data[i];
            end
        end
        out_req_d = granted;
    end

    assign in_ready = rst ? '0 : (granted | denied);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            out_req_q  <= '0;
            out_dest_q <= '0;
            out_data_q <= '0;
        end else begin
            rr_q       <= rr_d;
            out_req_q  <= out_req_d;
            out_dest_q <= out_dest_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_req  = out_req_q;
    assign out_dest = out_dest_q;
    assign out_data = out_data_q;

`ifdef XBAR_PERM_CHECK_EN
    logic [N-1:0][M-1:0]       perm_q, perm_d;
    logic [N-1:0]              deny_q, deny_d;
    logic [DENY_CNT_W-1:0]     deny_cnt_q, deny_cnt_d;
    logic [DENY_CNT_W:0]       deny_sum;

    // Requests this cycle are checked against perm_q; the write lands at the edge.
    always_comb begin
        perm_d = perm_q;
        for (int i = 0; i < N; i++) begin
            if (perm_we && perm_src == SRC_W'(i)) begin
                perm_d[i] = perm_mask;
            end
        end
        deny_d   = denied;
        deny_sum = {1'b0, deny_cnt_q};
        for (int i = 0; i < N; i++) begin
            deny_sum = deny_sum + (DENY_CNT_W + 1)'(denied[i]);
        end
        deny_cnt_d = deny_sum[DENY_CNT_W] ? '1 : deny_sum[DENY_CNT_W-1:0];
    end

    // NOTE: the permission table is a small flop array, so it is reset like any other state (to permit-all).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_q     <= '1;
            deny_q     <= '0;
            deny_cnt_q <= '0;
        end else begin
            perm_q     <= perm_d;
            deny_q     <= deny_d;
            deny_cnt_q <= deny_cnt_d;
        end
    end

    assign perm     = perm_q;
    assign deny     = deny_q;
    assign deny_cnt = deny_cnt_q;
`else
    logic unused_perm;
    assign unused_perm = ^{perm_we, perm_src, perm_mask};
    assign perm        = '1;
    assign deny        = '0;
    assign deny_cnt    = '0;
`endif

endmodule

// File: tb/tb_xbar_ingress_arbiter.sv
// Self-checking bench for xbar_ingress_arbiter: directed scenarios plus randomized
// traffic against a per-destination round-robin reference model.
module tb_xbar_ingress_arbiter;

    localparam int N      = 4;
    localparam int M      = 4;
    localparam int DW     = 32;
    localparam int DEST_W = 2;
    localparam int SRC_W  = 2;
`ifdef XBAR_PERM_CHECK_EN
    localparam bit PERM_EN = 1'b1;
`else
    localparam bit PERM_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             in_valid;
    logic [N-1:0][DEST_W-1:0] in_dest;
    logic [N-1:0][DW-1:0]     in_data;
    logic [N-1:0]             in_ready;
    logic [N-1:0]             out_req;
    logic [N-1:0][DEST_W-1:0] out_dest;
    logic [N-1:0][DW-1:0]     out_data;
    logic                     perm_we;
    logic [SRC_W-1:0]         perm_src;
    logic [M-1:0]             perm_mask;
    logic [N-1:0]             deny;
    logic [15:0]              deny_cnt;

    xbar_ingress_arbiter #(.N(N), .M(M), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_req   (out_req),
        .out_dest  (out_dest),
        .out_data  (out_data),
        .perm_we   (perm_we),
        .perm_src  (perm_src),
        .perm_mask (perm_mask),
        .deny      (deny),
        .deny_cnt  (deny_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [M-1:0]               m_perm [N];
    int                       m_rr   [M];
    logic [N-1:0]             m_req, m_deny;
    logic [N-1:0][DEST_W-1:0] m_dest;
    logic [N-1:0][DW-1:0]     m_data;
    int                       m_cnt;
    // Model next-state, computed before the edge from the applied inputs
    int                       nx_rr  [M];
    logic [N-1:0]             nx_req, nx_deny;
    logic [N-1:0][DEST_W-1:0] nx_dest;
    logic [N-1:0][DW-1:0]     nx_data;
    int                       nx_cnt;
    bit                       nx_pw;
    int                       nx_ps;
    bit [M-1:0]               nx_pm;
    logic [N-1:0]             last_ready;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_perm[i] = '1;
        for (int d = 0; d < M; d++) m_rr[d] = 0;
        m_req  = '0;
        m_deny = '0;
        m_dest = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    function automatic bit allowed(input int s, input int d);
        return (d < M) && (!PERM_EN || m_perm[s][d]);
    endfunction

    task automatic model_eval(output logic [N-1:0] exp_ready);
        bit found;
        int s;
        exp_ready = '0;
        nx_req    = '0;
        nx_deny   = '0;
        nx_dest   = m_dest;
        nx_data   = m_data;
        nx_cnt    = m_cnt;
        for (int d = 0; d < M; d++) nx_rr[d] = m_rr[d];
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && !allowed(i, int'(in_dest[i]))) begin
                exp_ready[i] = 1'b1;
                if (PERM_EN) begin
                    nx_deny[i] = 1'b1;
                    nx_cnt     = (nx_cnt < 65535) ? nx_cnt + 1 : 65535;
                end
            end
        end
        for (int d = 0; d < M; d++) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                s = (m_rr[d] + k) % N;
                if (!found && in_valid[s] && int'(in_dest[s]) == d && allowed(s, d)) begin
                    found        = 1'b1;
                    exp_ready[s] = 1'b1;
                    nx_req[s]    = 1'b1;
                    nx_dest[s]   = in_dest[s];
                    nx_data[s]   = in_data[s];
                    nx_rr[d]     = (s + 1) % N;
                end
            end
        end
        nx_pw = perm_we;
        nx_ps = int'(perm_src);
        nx_pm = perm_mask;
    endtask

    task automatic model_commit();
        m_req  = nx_req;
        m_deny = nx_deny;
        m_dest = nx_dest;
        m_data = nx_data;
        m_cnt  = nx_cnt;
        for (int d = 0; d < M; d++) m_rr[d] = nx_rr[d];
        if (PERM_EN && nx_pw) m_perm[nx_ps] = nx_pm;
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic do_cycle();
        logic [N-1:0] exp_ready;
        #1;
        model_eval(exp_ready);
        check("in_ready", in_ready, exp_ready);
        last_ready = exp_ready;
        @(posedge clk);
        model_commit();
        #1;
        check("out_req", out_req, m_req);
        check("out_dest", out_dest, m_dest);
        check("out_data", out_data, m_data);
        check("deny", deny, m_deny);
        check("deny_cnt", deny_cnt, 128'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = '0;
        in_dest   = '0;
        in_data   = '0;
        perm_we   = 1'b0;
        perm_src  = '0;
        perm_mask = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [N-1:0] seq032 [4];
    int           k_src;

    initial begin
        seq032[0] = 4'b0100;
        seq032[1] = 4'b0001;
        seq032[2] = 4'b0100;
        seq032[3] = 4'b0001;
        last_ready = '0;

        // Reset state, with requests pending: in_ready must stay low
        rst = 1'b1;
        idle();
        in_valid = '1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_req", out_req, 0);
        check("rst_out_data", out_data, 0);
        check("rst_deny_cnt", deny_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        model_reset();

        // Sources 0 and 2 contend for dest 1
        in_valid   = 4'b0101;
        in_dest[0] = 2'd1;
        in_dest[2] = 2'd1;
        in_data[0] = 32'h1111_0000;
        in_data[2] = 32'h2222_0000;
        #1;
        check("r031_ready", in_ready, 4'b0001);
        do_cycle();
        check("r031_out_req", out_req, 4'b0001);

        // Held contention alternates between the two sources
        for (int c = 0; c < 4; c++) begin
            #1;
            check("r032_ready", in_ready, seq032[c]);
            do_cycle();
        end

        // All sources to distinct destinations
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            in_dest[i] = DEST_W'(i);
            in_data[i] = 32'hA0 + i;
        end
        #1;
        check("r033_ready", in_ready, 4'b1111);
        do_cycle();
        check("r033_out_req", out_req, 4'hF);
        check("r033_out_data", out_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Revoke source 1 -> dest 0, then request it
        idle();
        perm_we   = 1'b1;
        perm_src  = 2'd1;
        perm_mask = 4'b1110;
        do_cycle();
        idle();
        in_valid   = 4'b0010;
        in_dest[1] = 2'd0;
        in_data[1] = 32'hDEAD_BEEF;
        #1;
        check("r034_ready", in_ready, 4'b0010);
        do_cycle();
        check("r034_out_req1", out_req[1], PERM_EN ? 1'b0 : 1'b1);
        check("r034_deny1", deny[1], PERM_EN);
        check("r034_deny_cnt", deny_cnt, PERM_EN ? 16'd1 : 16'd0);

        // Mid-contention reset: outputs clear without waiting for a clock edge
        in_valid = 4'b1111;
        in_dest  = '0;
        for (int i = 0; i < N; i++) in_data[i] = $urandom;
        do_cycle();
        do_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("r036_out_req", out_req, 0);
        check("r036_out_dest", out_dest, 0);
        check("r036_out_data", out_data, 0);
        check("r036_deny", deny, 0);
        check("r036_deny_cnt", deny_cnt, 0);
        check("r036_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("r036_in_ready_edge", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("r036_rr_zero", in_ready, 4'b0001);
        do_cycle();
        in_valid = 4'b0010;
        #1;
        check("r036_perm_ones", in_ready, 4'b0010);
        do_cycle();
        check("r036_perm_fwd", out_req, 4'b0010);

        // Randomized traffic; sources hold requests until consumed
        in_valid   = '0;
        last_ready = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || last_ready[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_dest[i]  = DEST_W'($urandom_range(0, M - 1));
                    in_data[i]  = $urandom;
                end
            end
            perm_we   = ($urandom_range(0, 7) == 0);
            perm_src  = SRC_W'($urandom_range(0, N - 1));
            perm_mask = M'($urandom | $urandom);
            do_cycle();
        end

        // Same-cycle write and request use the old table
        apply_reset();
        perm_we    = 1'b1;
        perm_src   = 2'd3;
        perm_mask  = 4'b0000;
        in_valid   = 4'b1000;
        in_dest[3] = 2'd2;
        in_data[3] = 32'h0BAD_F00D;
        #1;
        check("r035_old_ready", in_ready, 4'b1000);
        do_cycle();
        check("r035_old_fwd", out_req[3], 1'b1);
        perm_we = 1'b0;
        do_cycle();
        check("r035_new_req", out_req[3], PERM_EN ? 1'b0 : 1'b1);
        check("r035_new_deny", deny[3], PERM_EN);

        // Revoke everything, then drive the counter to 16'hFFFE
        idle();
        for (int i = 0; i < N; i++) begin
            perm_we   = 1'b1;
            perm_src  = SRC_W'(i);
            perm_mask = '0;
            do_cycle();
        end
        idle();
        for (int c = 0; c < 17000 && m_cnt < 65534; c++) begin
            k_src = 65534 - m_cnt;
            if (k_src > N) k_src = N;
            for (int i = 0; i < N; i++) begin
                in_valid[i] = (i < k_src);
                in_dest[i]  = DEST_W'(i);
                in_data[i]  = $urandom;
            end
            do_cycle();
        end
        check("r035_preload", deny_cnt, PERM_EN ? 16'hFFFE : 16'h0000);
        in_valid = 4'b0001;
        for (int c = 0; c < 3; c++) do_cycle();
        check("r035_sat", deny_cnt, PERM_EN ? 16'hFFFF : 16'h0000);
        in_valid = 4'b1111;
        do_cycle();
        check("r035_sat_hold", deny_cnt, PERM_EN ? 16'hFFFF : 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
